// File: rtl/mul_arb_ctrl_if.sv
// Request/result bundle for the two-requester pipelined multiplier.
// The master side issues operations and consumes results; the slave side is the multiplier.
interface mul_arb_ctrl_if #(
    parameter int WIDTH = 32
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [1:0]         req_signed;
    logic               flush;
    logic               res_valid;
    logic               res_ready;
    logic               res_id;
    logic [2*WIDTH-1:0] res_data;
    logic               busy;

    modport master (
        output req_valid, req_a, req_b, req_signed, flush, res_ready,
        input  req_ready, res_valid, res_id, res_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_signed, flush, res_ready,
        output req_ready, res_valid, res_id, res_data, busy
    );
endinterface

// File: rtl/mul_arb_ctrl.sv
// Two-requester round-robin front end feeding a 3-stage multiplier:
// radix-4 Booth partial products, 3:2 carry-save reduction, final add.
module mul_arb_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          resetn,
    mul_arb_ctrl_if.slave bus
);
    localparam int N   = WIDTH + 1;
    localparam int PW  = 2 * WIDTH;
    localparam int NPP = (WIDTH + 2) / 2;

    logic             ptr;
    logic             v1, v2, v3;
    logic             id1, id2, id3;
    logic [PW-1:0]    pp1 [NPP];
    logic [PW-1:0]    sum2, cry2, prod3;

    logic             stall, advance, gidx;
    logic [1:0]       grant;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_s;
    logic [N-1:0]     a_n, b_n;
    logic [PW-1:0]    a_x;
    logic [N+1:0]     b_x;
    logic [PW-1:0]    pp_c [NPP];
    logic [PW-1:0]    sum_c, cry_c;

    // Ready is gated by resetn so nothing is offered while reset is held.
    always_comb begin
        stall   = v3 & ~bus.res_ready;
        advance = ~stall & ~bus.flush & resetn;
        gidx    = 1'b0;
        grant   = 2'b00;
        if (advance) begin
            case (bus.req_valid)
                2'b01:   begin gidx = 1'b0; grant = 2'b01; end
                2'b10:   begin gidx = 1'b1; grant = 2'b10; end
                2'b11:   begin gidx = ptr;  grant = ptr ? 2'b10 : 2'b01; end
                default: begin gidx = 1'b0; grant = 2'b00; end
            endcase
        end
    end

    always_comb begin
        sel_a = gidx ? bus.req_a[PW-1:WIDTH] : bus.req_a[WIDTH-1:0];
        sel_b = gidx ? bus.req_b[PW-1:WIDTH] : bus.req_b[WIDTH-1:0];
        sel_s = gidx ? bus.req_signed[1] : bus.req_signed[0];
        a_n   = {sel_s & sel_a[WIDTH-1], sel_a};
        b_n   = {sel_s & sel_b[WIDTH-1], sel_b};
        a_x   = {{(PW-N){a_n[N-1]}}, a_n};
        b_x   = {b_n[N-1], b_n, 1'b0};
    end

    // Only the low PW bits are kept, so every partial product is formed modulo 2^PW.
    always_comb begin
        logic [2:0]    trip;
        logic [PW-1:0] mag;
        for (int j = 0; j < NPP; j++) begin
            trip = b_x[2*j +: 3];
            mag  = '0;
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = a_x;
                3'b011, 3'b100:                 mag = a_x << 1;
                default:                        mag = '0;
            endcase
            if (trip[2]) mag = ~mag + PW'(1);
            pp_c[j] = mag << (2*j);
        end
    end

    always_comb begin
        logic [PW-1:0] t;
        sum_c = pp1[0];
        cry_c = pp1[1];
        for (int j = 2; j < NPP; j++) begin
            t     = sum_c ^ cry_c ^ pp1[j];
            cry_c = ((sum_c & cry_c) | (sum_c & pp1[j]) | (cry_c & pp1[j])) << 1;
            sum_c = t;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr   <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            id1   <= 1'b0;
            id2   <= 1'b0;
            id3   <= 1'b0;
            sum2  <= '0;
            cry2  <= '0;
            prod3 <= '0;
            for (int j = 0; j < NPP; j++) pp1[j] <= '0;
        end else if (bus.flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (!stall) begin
            v1    <= |grant;
            id1   <= gidx;
            for (int j = 0; j < NPP; j++) pp1[j] <= pp_c[j];
            v2    <= v1;
            id2   <= id1;
            sum2  <= sum_c;
            cry2  <= cry_c;
            v3    <= v2;
            id3   <= id2;
            prod3 <= sum2 + cry2;
            if (|grant) ptr <= ~gidx;
        end
    end

    assign bus.req_ready = grant;
    assign bus.res_valid = v3;
    assign bus.res_id    = id3;
    assign bus.res_data  = prod3;
    assign bus.busy      = v1 | v2 | v3;
endmodule

// File: tb/tb_mul_arb_ctrl.sv
// Bench for mul_arb_ctrl: directed operand table, multi-cycle handshake sequences,
// and random traffic against a transaction-level reference.
module tb_mul_arb_ctrl;
    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mul_arb_ctrl_if #(.WIDTH(W)) bus ();
    mul_arb_ctrl #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sgn;
        logic [63:0]  prod;
    } vec_t;
    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint sa, sb;
        longint unsigned ua, ub;
        if (s) begin
            sa = $signed({{32{a[W-1]}}, a});
            sb = $signed({{32{b[W-1]}}, b});
            return sa * sb;
        end
        ua = {32'b0, a};
        ub = {32'b0, b};
        return ua * ub;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_idle();
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_signed = '0;
        bus.flush      = 1'b0;
        bus.res_ready  = 1'b1;
    endtask

    task automatic set_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (id) begin
            bus.req_a[2*W-1:W] = a;
            bus.req_b[2*W-1:W] = b;
            bus.req_signed[1]  = s;
        end else begin
            bus.req_a[W-1:0]  = a;
            bus.req_b[W-1:0]  = b;
            bus.req_signed[0] = s;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        resetn = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_id",    bus.res_id, 0);
        check("rst_res_data",  bus.res_data, 0);
        check("rst_busy",      bus.busy, 0);
        check("rst_req_ready", bus.req_ready, 0);
        @(negedge clk);
        resetn = 1'b1;
        bus.req_valid = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, got, acc, seen;
        logic [1:0]  exp_rdy, rv, sg;
        logic        rr, fl, gid;
        logic [W-1:0] a0, b0, a1, b1;
        bit          sv [3];
        bit          sid [3];
        logic [63:0] sd [3];
        bit          m_ptr, m_stall, m_adv;

        resetn = 1'b0;
        drive_idle();

        vecs[0] = '{1'b0, 32'd7,          32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{1'b0, 32'h8000_0000,  32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
        vecs[3] = '{1'b1, 32'h8000_0000,  32'd2,         1'b0, 64'h0000_0001_0000_0000};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001};
        vecs[5] = '{1'b1, 32'h8000_0000,  32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000};
        vecs[6] = '{1'b0, 32'd0,          32'h1234_5678, 1'b0, 64'h0000_0000_0000_0000};
        vecs[7] = '{1'b1, 32'd12345,      32'd6789,      1'b0, 64'h0000_0000_04FE_D79D};
        vecs[8] = '{1'b0, 32'hFFFF_FFFE,  32'd5,         1'b1, 64'hFFFF_FFFF_FFFF_FFF6};

        do_reset();

        // Isolated operations: one-cycle ready, 3-cycle latency, exact product.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.req_valid = 2'b01 << vecs[i].id;
            set_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sgn);
            #1;
            check("vec_ready", bus.req_ready, 2'b01 << vecs[i].id);
            n = 0;
            do begin
                @(negedge clk);
                bus.req_valid = '0;
                n++;
            end while (!bus.res_valid && n < 10);
            check("vec_latency", n, 3);
            check("vec_data", bus.res_data, vecs[i].prod);
            check("vec_id", bus.res_id, vecs[i].id);
        end

        // Contention with both requesters held.
        do_reset();
        got = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.req_valid = (k < 4) ? 2'b11 : 2'b00;
            set_op(1'b0, 32'd3, 32'd5, 1'b0);
            set_op(1'b1, 32'd11, 32'd13, 1'b0);
            #1;
            if (k < 4) check("cont_ready", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (bus.res_valid) begin
                check("cont_id", bus.res_id, got % 2);
                check("cont_data", bus.res_data, (got % 2 == 1) ? 64'd143 : 64'd15);
                check("cont_cycle", k, got + 3);
                got++;
            end
        end
        check("cont_count", got, 4);

        // Backpressure: consumer stalls five cycles from the first result.
        got = 0;
        acc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            rr = (k < 3 || k >= 8);
            bus.res_ready = rr;
            bus.req_valid = (acc < 4) ? 2'b01 : 2'b00;
            set_op(1'b0, 32'(100 + acc), 32'd3, 1'b0);
            #1;
            exp_rdy = (rr && acc < 4) ? 2'b01 : 2'b00;
            check("bp_ready", bus.req_ready, exp_rdy);
            if (k >= 3 && k <= 7) begin
                check("bp_hold_valid", bus.res_valid, 1);
                check("bp_hold_data", bus.res_data, 64'd300);
                check("bp_hold_id", bus.res_id, 0);
            end
            if (bus.res_valid && rr) begin
                if (got < 4) check("bp_data", bus.res_data, 64'((100 + got) * 3));
                got++;
            end
            if (exp_rdy != 2'b00) acc++;
        end
        check("bp_count", got, 4);
        check("bp_busy", bus.busy, 0);
        bus.res_ready = 1'b1;

        // Flush with three operations in flight.
        do_reset();
        got = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            bus.flush     = (k == 3);
            bus.res_ready = (k != 3);
            if (k < 4) begin
                bus.req_valid = 2'b11;
                set_op(1'b0, 32'd9, 32'd9, 1'b0);
                set_op(1'b1, 32'd9, 32'd9, 1'b0);
            end else if (k < 6) begin
                bus.req_valid = 2'b11;
                set_op(1'b0, 32'd2, 32'd3, 1'b0);
                set_op(1'b1, 32'd4, 32'd5, 1'b0);
            end else begin
                bus.req_valid = 2'b00;
            end
            #1;
            if (k < 3)  check("fl_pre_ready", bus.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 3) check("fl_ready", bus.req_ready, 2'b00);
            if (k == 4) begin
                check("fl_busy", bus.busy, 0);
                check("fl_res_valid", bus.res_valid, 0);
                check("fl_ptr_ready", bus.req_ready, 2'b10);
            end
            if (k == 5) check("fl_ptr_ready2", bus.req_ready, 2'b01);
            if (k >= 4 && bus.res_valid) begin
                check("fl_id", bus.res_id, (got == 0) ? 1 : 0);
                check("fl_data", bus.res_data, (got == 0) ? 64'd20 : 64'd6);
                got++;
            end
        end
        check("fl_count", got, 2);

        // Reset asserted with all three stages occupied.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.req_valid = 2'b01;
            set_op(1'b0, 32'(k + 1), 32'd7, 1'b0);
            if (k == 3) begin
                resetn = 1'b0;
                #1;
                check("mrst_res_valid", bus.res_valid, 0);
                check("mrst_res_data",  bus.res_data, 0);
                check("mrst_res_id",    bus.res_id, 0);
                check("mrst_busy",      bus.busy, 0);
                check("mrst_ready",     bus.req_ready, 0);
            end
        end
        @(negedge clk);
        resetn = 1'b1;
        bus.req_valid = '0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        check("mrst_no_result", seen, 0);
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        check("mrst_first_grant", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid = '0;

        // Random traffic against a transaction-level reference.
        do_reset();
        m_ptr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sv[i] = 1'b0; sid[i] = 1'b0; sd[i] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rv = 2'($urandom_range(0, 3));
            fl = ($urandom_range(0, 15) == 0);
            rr = ($urandom_range(0, 3) != 0);
            sg = 2'($urandom_range(0, 3));
            a0 = rand_op(); b0 = rand_op();
            a1 = rand_op(); b1 = rand_op();
            bus.req_valid = rv;
            bus.flush     = fl;
            bus.res_ready = rr;
            set_op(1'b0, a0, b0, sg[0]);
            set_op(1'b1, a1, b1, sg[1]);
            #1;
            m_stall = sv[2] && !rr;
            m_adv   = !m_stall && !fl;
            gid     = (rv == 2'b11) ? m_ptr : (rv == 2'b10);
            exp_rdy = (m_adv && rv != 2'b00) ? (gid ? 2'b10 : 2'b01) : 2'b00;
            check("rnd_ready", bus.req_ready, exp_rdy);
            check("rnd_res_valid", bus.res_valid, sv[2]);
            if (sv[2]) begin
                check("rnd_res_id", bus.res_id, sid[2]);
                check("rnd_res_data", bus.res_data, sd[2]);
            end
            check("rnd_busy", bus.busy, sv[0] | sv[1] | sv[2]);
            if (fl) begin
                sv[0] = 1'b0; sv[1] = 1'b0; sv[2] = 1'b0;
            end else if (!m_stall) begin
                sv[2] = sv[1]; sid[2] = sid[1]; sd[2] = sd[1];
                sv[1] = sv[0]; sid[1] = sid[0]; sd[1] = sd[0];
                sv[0]  = (exp_rdy != 2'b00);
                sid[0] = gid;
                sd[0]  = gid ? ref_mul(a1, b1, sg[1]) : ref_mul(a0, b0, sg[0]);
                if (exp_rdy != 2'b00) m_ptr = !gid;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_arb_ctrl.md
MUL_ARB_CTRL -- requirements
Module: mul_arb_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand width per requester.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  2  bit i: requester i presents an operation.
REQ-005 req_ready  output  2  bit i: requester i operation accepted this cycle.
REQ-006 req_a  input  2*WIDTH  multiplicand; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 req_b  input  2*WIDTH  multiplier; same packing as req_a.
REQ-008 req_signed  input  2  bit i: 1 = signed x signed, 0 = unsigned x unsigned.
REQ-009 flush  input  1  synchronous pipeline kill.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 res_id  output  1  index of the requester that issued the result.
REQ-013 res_data  output  2*WIDTH  full product.
REQ-014 busy  output  1  any pipeline stage occupied.

Function
REQ-015 Datapath SHALL be three registered stages: S1 radix-4 Booth partial-product generation, S2 Wallace carry-save reduction to two rows, S3 final carry-propagate add; each stage has a valid bit v1/v2/v3 and carries the 1-bit id.
REQ-016 Operands SHALL be extended to WIDTH+1 bits (sign-extend when req_signed=1, zero-extend otherwise) before Booth encoding; res_data SHALL be the low 2*WIDTH bits of the exact product.
REQ-017 Stall SHALL be v3 & !res_ready; on stall, all stages hold contents (global stall, no bubble collapse).
REQ-018 Advance SHALL be !stall & !flush; at most one request accepted per cycle, only when advance=1.
REQ-019 Arbitration SHALL be round-robin with a 1-bit priority pointer: if both valid, grant the pointer index; if one valid, grant it; pointer becomes (granted index ^ 1) after each grant, unchanged otherwise.
REQ-020 req_ready SHALL be combinational, one-hot or zero, equal to the grant; req_ready[i] SHALL never be 1 while req_valid[i]=0.
REQ-021 Latency SHALL be 3 cycles: a request accepted at edge N yields res_valid=1 after edge N+3 when not stalled; sustained throughput 1 result/cycle.
REQ-022 res_valid SHALL equal v3; res_data and res_id SHALL remain stable while res_valid=1 and res_ready=0.
REQ-023 A result SHALL retire on the edge where res_valid & res_ready; a new result may load into S3 on the same edge.
REQ-024 flush=1 SHALL clear v1, v2, v3 at the next edge, drop any in-flight results, force req_ready=0 that cycle, and leave the priority pointer unchanged; flush takes precedence over stall and acceptance.
REQ-025 busy SHALL be v1 | v2 | v3.
REQ-026 Corner operands: signed -2^(WIDTH-1) x -2^(WIDTH-1) SHALL yield 2^(2*WIDTH-2); unsigned all-ones x all-ones SHALL yield (2^WIDTH-1)^2 exactly.

Reset
REQ-027 While resetn=0: v1=v2=v3=0, priority pointer=0, stage data and ids=0, so res_valid=0, res_id=0, res_data=0, busy=0, req_ready=0.
REQ-028 Reset assertion mid-operation SHALL discard all in-flight operations without producing a result; first grant after release follows pointer=0.

Verification
REQ-029 Single op: req_valid=01, a0=7, b0=-3, signed=1 -> req_ready=01 one cycle, res_valid 3 cycles later, res_data=-21 (0xFFFFFFFFFFFFFFEB), res_id=0.
REQ-030 Contention: req_valid=11 held, res_ready=1 -> grants alternate 01,10,01,10; results return in same order, ids 0,1,0,1, one per cycle.
REQ-031 Backpressure: four back-to-back ops, res_ready=0 for 5 cycles after first res_valid -> first result held stable, req_ready=0 while stalled, no loss or duplication, all four delivered after release.
REQ-032 Width corners: unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001; signed 0x80000000 x 0x80000000 -> 0x4000000000000000; unsigned 0x80000000 x 2 -> 0x100000000.
REQ-033 Flush: three ops in flight, flush=1 one cycle -> next cycle busy=0, res_valid=0, none of the three ever returned; pointer order preserved for next grants.
REQ-034 Reset mid-stream: resetn low 1 cycle with v1..v3 set -> all outputs 0 immediately, no result emitted after release.
